// File: rtl/powermod_arbiter_pkg.sv
// Shared types and default sizing for the powermod arbiter slice.
package powermod_arbiter_pkg;

  localparam int unsigned DefNReq    = 4;
  localparam int unsigned DefWidth   = 8;
  localparam int unsigned DefTimeout = 1023;

  // Controller state encoding.
  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StIssue = 2'b01,
    StWait  = 2'b10,
    StDone  = 2'b11
  } state_e;

  // Index width for a requester count; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/powermod_arbiter_rr_picker.sv
// Combinational round-robin picker: one-hot select of the first requester after `last`.
module powermod_arbiter_rr_picker
  import powermod_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = DefNReq,
  localparam int unsigned IdxW = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IdxW-1:0]  last,
  output logic [N_REQ-1:0] pick,
  output logic [IdxW-1:0]  pick_idx,
  output logic             valid
);

  int unsigned cand;

  // Scan from last+1 around the ring; the first hit wins, so pick is always one-hot or zero.
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    valid    = 1'b0;
    cand     = 0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = (32'(last) + i) % N_REQ;
      if (!valid && req[cand[IdxW-1:0]]) begin
        valid                  = 1'b1;
        pick_idx               = cand[IdxW-1:0];
        pick[cand[IdxW-1:0]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/powermod_arbiter.sv
// Round-robin arbiter sharing one modular-exponentiation engine among N_REQ requesters.
module powermod_arbiter
  import powermod_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ   = DefNReq,
  parameter int unsigned WIDTH   = DefWidth,
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] a_in,
  input  logic [N_REQ*WIDTH-1:0] b_in,
  input  logic [N_REQ*WIDTH-1:0] m_in,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   done,
  output logic [WIDTH-1:0]   result,
  output logic               err,
  output logic               busy,
  output logic               pm_start,
  output logic [WIDTH-1:0]   pm_a,
  output logic [WIDTH-1:0]   pm_b,
  output logic [WIDTH-1:0]   pm_m,
  input  logic [WIDTH-1:0]   pm_res,
  input  logic               pm_rdy
);

  localparam int unsigned IdxW = idx_width(N_REQ);
  // Counter only needs to reach TIMEOUT-1: the wait ends on the cycle the count hits TIMEOUT.
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IdxW-1:0]  owner_q, owner_d;
  logic [IdxW-1:0]  last_q, last_d;
  logic [WIDTH-1:0] pm_a_q, pm_a_d;
  logic [WIDTH-1:0] pm_b_q, pm_b_d;
  logic [WIDTH-1:0] pm_m_q, pm_m_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;

  logic [N_REQ-1:0] pick;
  logic [IdxW-1:0]  pick_idx;
  logic             pick_valid;
  logic [WIDTH-1:0] cap_a, cap_b, cap_m;

  powermod_arbiter_rr_picker #(
    .N_REQ (N_REQ)
  ) u_rr_picker (
    .req      (req),
    .last     (last_q),
    .pick     (pick),
    .pick_idx (pick_idx),
    .valid    (pick_valid)
  );

  // One-hot operand mux for the winning slot.
  always_comb begin
    cap_a = '0;
    cap_b = '0;
    cap_m = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick[i]) begin
        cap_a = a_in[i*WIDTH +: WIDTH];
        cap_b = b_in[i*WIDTH +: WIDTH];
        cap_m = m_in[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state and strobe outputs; with ena low everything holds and no strobe fires.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    last_d   = last_q;
    pm_a_d   = pm_a_q;
    pm_b_d   = pm_b_q;
    pm_m_d   = pm_m_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    err_d    = err_q;
    pm_start = 1'b0;
    done     = '0;
    if (ena) begin
      unique case (state_q)
        StIdle: begin
          if (pick_valid) begin
            state_d = StIssue;
            grant_d = pick;
            owner_d = pick_idx;
            pm_a_d  = cap_a;
            pm_b_d  = cap_b;
            pm_m_d  = cap_m;
            err_d   = 1'b0;
          end
        end
        StIssue: begin
          cnt_d = '0;
          if (pm_m_q == '0) begin
            // Modulus zero is undefined; report it without touching the engine.
            state_d  = StDone;
            result_d = '0;
            err_d    = 1'b1;
          end else begin
            pm_start = 1'b1;
            state_d  = StWait;
          end
        end
        StWait: begin
          if (pm_rdy) begin
            state_d  = StDone;
            result_d = pm_res;
            err_d    = 1'b0;
          end else if (cnt_q == CntLast) begin
            state_d  = StDone;
            result_d = '0;
            err_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StDone: begin
          done    = grant_q;
          last_d  = owner_q;
          grant_d = '0;
          err_d   = 1'b0;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      owner_q  <= '0;
      last_q   <= IdxW'(N_REQ - 1);
      pm_a_q   <= '0;
      pm_b_q   <= '0;
      pm_m_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      pm_a_q   <= pm_a_d;
      pm_b_q   <= pm_b_d;
      pm_m_q   <= pm_m_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign grant  = grant_q;
  assign result = result_q;
  assign err    = err_q;
  assign busy   = (state_q != StIdle);
  assign pm_a   = pm_a_q;
  assign pm_b   = pm_b_q;
  assign pm_m   = pm_m_q;

endmodule
